scarv_soc_bram_arbiter: RTL and testbench
=========================================

// Module: scarv_soc_bram_arbiter
// PURPOSE
//  Shares one single-port, 1-cycle-latency SRAM/BRAM between two requesters.
//  Port 0 is the CPU instruction fetch and port 1 is the CPU data port.
//  Each port uses a req/gnt request channel and a valid/ready response channel.
//  At most one transaction is in flight, and a stalled response is held in a register.
// PARAMETERS
//  AW            14   byte-address width of the memory ports
//  FIXED_PRIO    0    0 = round-robin between p0/p1; 1 = p1 always wins ties
// PORTS
//  g_clk            in   1   clock
//  g_resetn         in   1   async active-low reset
//  pN_req           in   1   request valid (N = 0,1; identical port sets)
//  pN_gnt           out  1   request accepted this cycle (transfer = req & gnt)
//  pN_wen           in   1   1 = write, 0 = read
//  pN_strb          in   4   byte write strobes (ignored when wen = 0)
//  pN_addr          in   AW  byte address; [1:0] passed through unchanged
//  pN_wdata         in   32  write data
//  pN_rsp_valid     out  1   response valid
//  pN_rsp_ready     in   1   response accepted (transfer = valid & ready)
//  pN_rsp_rdata     out  32  read data (pre-write word for writes)
//  bram_en          out  1   memory enable
//  bram_we          out  4   memory byte write enables
//  bram_addr        out  AW  memory address
//  bram_wdata       out  32  memory write data
//  bram_rdata       in   32  memory read data, valid the cycle after bram_en
// BEHAVIOUR
//  - FSM states: IDLE, RESP(p), HOLD(p), where p is the owning port.
//    Reset state is IDLE, last-grant pointer = p1 (so p0 wins the first tie),
//    hold register = 0.
//  - Outputs during reset are all 0.
//    A reset mid-transaction drops the in-flight response, and no rsp_valid is generated.
//  - Grant is combinational (paths req->gnt and rsp_ready->gnt exist).
//    A grant is allowed when:
//      IDLE;
//      RESP(p) with pP_rsp_ready = 1.
//    A grant is never allowed in HOLD(p).
//  - Selection:
//      one requester -> it is granted;
//      both requesting -> round-robin (the port not granted last) or p1 if FIXED_PRIO.
//    The pointer updates only on a grant.
//  - On a grant in cycle N:
//      bram_en = 1;
//      bram_we = wen ? strb : 4'b0;
//      bram_addr / bram_wdata = the granted port's addr / wdata.
//    With no grant: bram_en = 0 and bram_we = 0; addr/wdata are don't-care and held at the last value.
//  - Cycle N+1: the state is RESP(p); pP_rsp_valid = 1 and pP_rsp_rdata = bram_rdata.
//  - RESP(p) transitions:
//      ready = 1 and new grant to q -> RESP(q);
//      ready = 1 and no grant -> IDLE;
//      ready = 0 -> capture bram_rdata into the hold register -> HOLD(p).
//  - HOLD(p): rsp_valid = 1 and rdata = hold register, stable until ready.
//    On ready the FSM goes to IDLE; the next grant is possible in the following cycle.
//  - A write is acknowledged through a response like a read.
//    rdata = the word before the write (read-first memory).
//  - rsp_valid is never asserted on the non-owning port.
//    At most one rsp_valid is high per cycle.
//  - Throughput: 1 transaction per cycle when rsp_ready stays high.
//    Latency from req & gnt to rsp_valid is 1 cycle.
//  - The requester must hold req/addr/wdata/wen/strb stable until gnt; this is not checked.
// STRUCTURE
//  - Package scarv_soc_bram_arb_pkg: FSM state encoding (IDLE/RESP/HOLD), port-id
//    constants P0/P1, BRAM_LATENCY = 1.
//  - Sub-module scarv_soc_rr_arb2 (2-way round-robin picker with FIXED_PRIO):
//    inputs req[1:0], advance; outputs one-hot gnt[1:0].
//  - Top level: FSM, owner register, hold register, and the BRAM-side output muxes.
// TESTING
//  1. p0 read addr 0x10 (mem = 0xDEADBEEF), rsp_ready = 1
//     -> p0_gnt in cycle N; bram_en = 1, we = 0; p0_rsp_valid in N+1 with rdata 0xDEADBEEF.
//  2. p1 write 0x20, strb 4'b0011, wdata 0x11223344 over 0xAAAAAAAA, then read 0x20
//     -> the write response rdata = 0xAAAAAAAA; the read returns 0xAAAA3344.
//  3. p0 and p1 request continuously, FIXED_PRIO = 0
//     -> grants alternate p0, p1, p0, ...; bram_en = 1 every cycle.
//  4. p0 read with p0_rsp_ready = 0 for 3 cycles while p1 requests
//     -> HOLD: p0_rdata stable, p1_gnt = 0 until ready; p1 is granted the cycle after acceptance.
//  5. FIXED_PRIO = 1, both requesting
//     -> p1 is granted every cycle; p0 is granted only when p1_req = 0.
//  6. Assert g_resetn = 0 in the cycle after a grant
//     -> all outputs 0 and no rsp_valid; after release, a p0/p1 tie grants p0.

Source files
------------

// File: rtl/scarv_soc_bram_arbiter_pkg.sv
// Shared definitions for the two-port BRAM arbiter: FSM encoding, port ids
// and the memory read latency the FSM is built around.
package scarv_soc_bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } arb_state_e;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  localparam int BRAM_LATENCY = 1;

endpackage

// File: rtl/scarv_soc_rr_arb2.sv
// Two-way request picker: round-robin on ties, or port 1 always wins ties
// when FIXED_PRIO is set. The pointer only moves when advance is asserted.
module scarv_soc_rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic       g_clk,
  input  logic       g_resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (FIXED_PRIO || !last_q) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance && (gnt != 2'b00)) last_d = gnt[1];
  end

  // Pointer resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) last_q <= 1'b1;
    else           last_q <= last_d;
  end

endmodule

// File: rtl/scarv_soc_bram_arbiter.sv
// Shares one single-port, 1-cycle-latency BRAM between instruction fetch (p0)
// and data (p1) ports; one transaction in flight, stalled responses are held.
module scarv_soc_bram_arbiter
  import scarv_soc_bram_arb_pkg::*;
#(
  parameter int AW         = 14,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          p0_req,
  output logic          p0_gnt,
  input  logic          p0_wen,
  input  logic [3:0]    p0_strb,
  input  logic [AW-1:0] p0_addr,
  input  logic [31:0]   p0_wdata,
  output logic          p0_rsp_valid,
  input  logic          p0_rsp_ready,
  output logic [31:0]   p0_rsp_rdata,
  input  logic          p1_req,
  output logic          p1_gnt,
  input  logic          p1_wen,
  input  logic [3:0]    p1_strb,
  input  logic [AW-1:0] p1_addr,
  input  logic [31:0]   p1_wdata,
  output logic          p1_rsp_valid,
  input  logic          p1_rsp_ready,
  output logic [31:0]   p1_rsp_rdata,
  output logic          bram_en,
  output logic [3:0]    bram_we,
  output logic [AW-1:0] bram_addr,
  output logic [31:0]   bram_wdata,
  input  logic [31:0]   bram_rdata
);

  arb_state_e    state_q, state_d;
  logic          owner_q, owner_d;
  logic [31:0]   hold_q, hold_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic       own_ready;
  logic       allow;
  logic [1:0] pick;
  logic [1:0] gnt;
  logic       any_gnt;
  logic       sel;
  logic       rsp_valid;
  logic [31:0] rsp_rdata;

  assign own_ready = (owner_q == P1) ? p1_rsp_ready : p0_rsp_ready;

  // Gated by g_resetn so no grant (and no BRAM access) leaks out during reset.
  assign allow = g_resetn &&
                 ((state_q == ST_IDLE) || ((state_q == ST_RESP) && own_ready));

  scarv_soc_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .req      ({p1_req, p0_req}),
    .advance  (allow),
    .gnt      (pick)
  );

  assign gnt     = pick & {2{allow}};
  assign any_gnt = |gnt;
  assign sel     = gnt[1];
  assign p0_gnt  = gnt[0];
  assign p1_gnt  = gnt[1];

  always_comb begin
    bram_en    = any_gnt;
    bram_we    = 4'b0000;
    bram_addr  = addr_q;
    bram_wdata = wdata_q;
    if (any_gnt) begin
      bram_addr  = sel ? p1_addr  : p0_addr;
      bram_wdata = sel ? p1_wdata : p0_wdata;
      if (sel ? p1_wen : p0_wen) bram_we = sel ? p1_strb : p0_strb;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (any_gnt) begin
          state_d = ST_RESP;
          owner_d = sel;
        end
      end
      ST_RESP: begin
        if (own_ready) begin
          state_d = any_gnt ? ST_RESP : ST_IDLE;
          if (any_gnt) owner_d = sel;
        end else begin
          state_d = ST_HOLD;
          hold_d  = bram_rdata;
        end
      end
      ST_HOLD: begin
        if (own_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= ST_IDLE;
      owner_q <= P0;
      hold_q  <= 32'h0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      addr_q  <= bram_addr;
      wdata_q <= bram_wdata;
    end
  end

  assign rsp_valid = (state_q != ST_IDLE);
  assign rsp_rdata = (state_q == ST_RESP) ? bram_rdata :
                     (state_q == ST_HOLD) ? hold_q : 32'h0;

  assign p0_rsp_valid = rsp_valid && (owner_q == P0);
  assign p1_rsp_valid = rsp_valid && (owner_q == P1);
  assign p0_rsp_rdata = p0_rsp_valid ? rsp_rdata : 32'h0;
  assign p1_rsp_rdata = p1_rsp_valid ? rsp_rdata : 32'h0;

endmodule

// File: tb/tb_scarv_soc_bram_arbiter.sv
// Directed bench for the BRAM arbiter: a round-robin instance with a
// read-first memory model, plus a fixed-priority instance sharing the inputs.
module tb_scarv_soc_bram_arbiter;

  localparam int AW = 14;

  logic          g_clk = 1'b0;
  logic          g_resetn = 1'b0;
  logic          p0_req = 0, p0_wen = 0, p0_rsp_ready = 1;
  logic [3:0]    p0_strb = 0;
  logic [AW-1:0] p0_addr = 0;
  logic [31:0]   p0_wdata = 0;
  logic          p1_req = 0, p1_wen = 0, p1_rsp_ready = 1;
  logic [3:0]    p1_strb = 0;
  logic [AW-1:0] p1_addr = 0;
  logic [31:0]   p1_wdata = 0;

  logic          p0_gnt, p0_rsp_valid, p1_gnt, p1_rsp_valid;
  logic [31:0]   p0_rsp_rdata, p1_rsp_rdata;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic [31:0]   bram_rdata = 32'h0;

  logic          f_p0_gnt, f_p0_rsp_valid, f_p1_gnt, f_p1_rsp_valid;
  logic [31:0]   f_p0_rsp_rdata, f_p1_rsp_rdata;
  logic          f_bram_en;
  logic [3:0]    f_bram_we;
  logic [AW-1:0] f_bram_addr;
  logic [31:0]   f_bram_wdata;
  logic [31:0]   f_bram_rdata = 32'h0;

  logic [31:0]   mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 g_clk = ~g_clk;

  scarv_soc_bram_arbiter #(.AW(AW), .FIXED_PRIO(1'b0)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .p0_req(p0_req), .p0_gnt(p0_gnt), .p0_wen(p0_wen), .p0_strb(p0_strb),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
    .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_wen(p1_wen), .p1_strb(p1_strb),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  scarv_soc_bram_arbiter #(.AW(AW), .FIXED_PRIO(1'b1)) dut_fix (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .p0_req(p0_req), .p0_gnt(f_p0_gnt), .p0_wen(p0_wen), .p0_strb(p0_strb),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rsp_valid(f_p0_rsp_valid),
    .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(f_p0_rsp_rdata),
    .p1_req(p1_req), .p1_gnt(f_p1_gnt), .p1_wen(p1_wen), .p1_strb(p1_strb),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rsp_valid(f_p1_rsp_valid),
    .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(f_p1_rsp_rdata),
    .bram_en(f_bram_en), .bram_we(f_bram_we), .bram_addr(f_bram_addr),
    .bram_wdata(f_bram_wdata), .bram_rdata(f_bram_rdata)
  );

  // Read-first memory; output is garbage in cycles without an access.
  always @(posedge g_clk) begin
    if (bram_en) begin
      bram_rdata <= mem[bram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr[9:2]][b*8 +: 8] <= bram_wdata[b*8 +: 8];
    end else begin
      bram_rdata <= 32'h0BAD0BAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hAAAAAAAA;

    // Reset: outputs all zero even with a request pending.
    p0_req = 1;
    #2;
    chk("rst_p0_gnt", p0_gnt, 0);
    chk("rst_bram_en", bram_en, 0);
    chk("rst_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    p0_req = 0;
    tick(); tick();
    g_resetn = 1;
    tick();

    // 1: p0 read 0x10
    p0_req = 1; p0_addr = 14'h10;
    #3;
    chk("t1_p0_gnt", p0_gnt, 1);
    chk("t1_p1_gnt", p1_gnt, 0);
    chk("t1_bram_en", bram_en, 1);
    chk("t1_bram_we", bram_we, 0);
    chk("t1_bram_addr", bram_addr, 14'h10);
    tick();
    p0_req = 0;
    #3;
    chk("t1_rsp_valid", p0_rsp_valid, 1);
    chk("t1_rsp_rdata", p0_rsp_rdata, 32'hDEADBEEF);
    chk("t1_p1_valid", p1_rsp_valid, 0);
    chk("t1_idle_en", bram_en, 0);
    tick();

    // 2: p1 partial write, then read back
    p1_req = 1; p1_wen = 1; p1_strb = 4'b0011; p1_addr = 14'h20; p1_wdata = 32'h11223344;
    #3;
    chk("t2_wr_gnt", p1_gnt, 1);
    chk("t2_wr_we", bram_we, 4'b0011);
    chk("t2_wr_wdata", bram_wdata, 32'h11223344);
    tick();
    p1_wen = 0;
    #3;
    chk("t2_wr_rsp_valid", p1_rsp_valid, 1);
    chk("t2_wr_rsp_rdata", p1_rsp_rdata, 32'hAAAAAAAA);
    chk("t2_rd_gnt", p1_gnt, 1);
    chk("t2_rd_we", bram_we, 0);
    tick();
    p1_req = 0;
    #3;
    chk("t2_rd_rdata", p1_rsp_rdata, 32'hAAAA3344);
    tick();

    // 3: continuous contention, round-robin
    p0_req = 1; p1_req = 1; p0_addr = 14'h10; p1_addr = 14'h10;
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("t3_p0_gnt", p0_gnt, (k % 2 == 0));
      chk("t3_p1_gnt", p1_gnt, (k % 2 == 1));
      chk("t3_bram_en", bram_en, 1);
      if (k > 0) chk("t3_rsp_owner", {p1_rsp_valid, p0_rsp_valid}, (k % 2 == 1) ? 2'b01 : 2'b10);
      tick();
    end
    p0_req = 0; p1_req = 0;
    tick();

    // 4: stalled p0 response held while p1 waits
    p0_req = 1; p0_rsp_ready = 0;
    #3;
    chk("t4_p0_gnt", p0_gnt, 1);
    tick();
    p0_req = 0; p1_req = 1; p1_addr = 14'h20;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("t4_hold_valid", p0_rsp_valid, 1);
      chk("t4_hold_rdata", p0_rsp_rdata, 32'hDEADBEEF);
      chk("t4_hold_p1_gnt", p1_gnt, 0);
      chk("t4_hold_p1_valid", p1_rsp_valid, 0);
      tick();
      if (k == 1) p0_rsp_ready = 1;
    end
    #3;
    chk("t4_after_p1_gnt", p1_gnt, 1);
    chk("t4_after_p0_valid", p0_rsp_valid, 0);
    tick();
    p1_req = 0;
    #3;
    chk("t4_p1_rsp", p1_rsp_rdata, 32'hAAAA3344);
    tick();

    // 6: reset the cycle after a grant
    p1_req = 1; p1_addr = 14'h10;
    #3;
    chk("t6_p1_gnt", p1_gnt, 1);
    tick();
    g_resetn = 0; p0_req = 1; p1_req = 1;
    #3;
    chk("t6_rst_valid", {p0_rsp_valid, p1_rsp_valid}, 0);
    chk("t6_rst_rdata", p1_rsp_rdata, 0);
    chk("t6_rst_gnt", {p0_gnt, p1_gnt}, 0);
    chk("t6_rst_en", bram_en, 0);
    tick();
    g_resetn = 1;
    #3;
    chk("t6_tie_p0", {p1_gnt, p0_gnt}, 2'b01);
    chk("t6_no_rsp", {p0_rsp_valid, p1_rsp_valid}, 0);

    // 5: fixed-priority instance, both requesting
    for (int k = 0; k < 4; k++) begin
      chk("t5_fix_gnt", {f_p1_gnt, f_p0_gnt}, 2'b10);
      tick();
      #3;
    end
    p1_req = 0;
    #1;
    chk("t5_fix_p0_gnt", {f_p1_gnt, f_p0_gnt}, 2'b01);
    tick();
    p0_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
